// File: rtl/pe_mac_param.sv
// Parametrised output-stationary systolic PE: forwards operands east/south and
// sums K_DEPTH products per tile. Define PE_SAT_EN for saturating sums + sticky ovf_out.
module pe_mac_param #(
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 32,
   parameter int K_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic              signed_mode,
   input  logic              flush,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              valid_out,
   output logic [ACC_W-1:0]  y_out,
   output logic              y_valid,
   output logic              ovf_out
);

   localparam int CNT_W = $clog2(K_DEPTH + 1);

   typedef enum logic {IDLE, ACCUM} state_e;

   state_e               state_q;
   logic [CNT_W-1:0]     count_q;
   logic [ACC_W-1:0]     acc_q;
   logic [ACC_W-1:0]     y_q;
   logic [DATA_W-1:0]    a_q;
   logic [DATA_W-1:0]    b_q;
   logic                 valid_q;
   logic                 y_valid_q;

   logic [2*DATA_W-1:0]  a_ext;
   logic [2*DATA_W-1:0]  b_ext;
   logic [2*DATA_W-1:0]  prod;
   logic signed [2*DATA_W:0] prod_x;
   logic [ACC_W-1:0]     sum_d;
   logic                 close_d;
   logic                 drain_d;

`ifdef PE_SAT_EN
   localparam logic signed [ACC_W+1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W+1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};
   logic signed [ACC_W+1:0] sum_w;
   logic                    sat_d;
   logic                    ovf_q;
`endif

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      // Extending by the mode bit lets one multiplier serve both signed and unsigned operands.
      a_ext  = {{DATA_W{signed_mode & a_in[DATA_W-1]}}, a_in};
      b_ext  = {{DATA_W{signed_mode & b_in[DATA_W-1]}}, b_in};
      prod   = a_ext * b_ext;
      prod_x = {signed_mode & prod[2*DATA_W-1], prod};
`ifdef PE_SAT_EN
      sum_w = (ACC_W+2)'($signed(acc_q)) + (ACC_W+2)'(prod_x);
      sat_d = 1'b0;
      sum_d = sum_w[ACC_W-1:0];
      if (sum_w > SAT_MAX) begin
         sum_d = SAT_MAX[ACC_W-1:0];
         sat_d = 1'b1;
      end else if (sum_w < SAT_MIN) begin
         sum_d = SAT_MIN[ACC_W-1:0];
         sat_d = 1'b1;
      end
`else
      sum_d = acc_q + ACC_W'(prod_x);
`endif
   end

   assign close_d = valid_in & (flush | (count_q == CNT_W'(K_DEPTH - 1)));
   assign drain_d = ~valid_in & flush & (state_q == ACCUM);

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         acc_q     <= '0;
         y_q       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         valid_q   <= 1'b0;
         y_valid_q <= 1'b0;
      end else begin
         valid_q   <= valid_in;
         y_valid_q <= 1'b0;
         if (valid_in) begin
            a_q <= a_in;
            b_q <= b_in;
         end
         if (close_d) begin
            y_q       <= sum_d;
            y_valid_q <= 1'b1;
            acc_q     <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
         end else if (valid_in) begin
            acc_q   <= sum_d;
            count_q <= count_q + CNT_W'(1);
            state_q <= ACCUM;
         end else if (drain_d) begin
            y_q       <= acc_q;
            y_valid_q <= 1'b1;
            acc_q     <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
         end
      end
   end

`ifdef PE_SAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 ovf_q <= 1'b0;
      else if (valid_in & sat_d) ovf_q <= 1'b1;
   end
   assign ovf_out = ovf_q;
`else
   assign ovf_out = 1'b0;
`endif

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign valid_out = valid_q;
   assign y_out     = y_q;
   assign y_valid   = y_valid_q;

endmodule

// File: tb/tb_pe_mac_param.sv
// Bench for pe_mac_param: three instances (default, ACC_W=16, K_DEPTH=1) on shared
// inputs, compared each cycle with an arithmetic model, plus directed vectors.
module tb_pe_mac_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in, signed_mode, flush;
   logic [7:0]  a_in, b_in;
   logic [7:0]  ao [3];
   logic [7:0]  bo [3];
   logic        vo [3];
   logic        yv [3];
   logic        ov [3];
   logic [31:0] y_a, y_c;
   logic [15:0] y_b;

   pe_mac_param #(.DATA_W(8), .ACC_W(32), .K_DEPTH(8)) u_a (
      .clk(clk), .reset(reset), .valid_in(valid_in), .signed_mode(signed_mode), .flush(flush),
      .a_in(a_in), .b_in(b_in), .a_out(ao[0]), .b_out(bo[0]), .valid_out(vo[0]),
      .y_out(y_a), .y_valid(yv[0]), .ovf_out(ov[0]));
   pe_mac_param #(.DATA_W(8), .ACC_W(16), .K_DEPTH(8)) u_b (
      .clk(clk), .reset(reset), .valid_in(valid_in), .signed_mode(signed_mode), .flush(flush),
      .a_in(a_in), .b_in(b_in), .a_out(ao[1]), .b_out(bo[1]), .valid_out(vo[1]),
      .y_out(y_b), .y_valid(yv[1]), .ovf_out(ov[1]));
   pe_mac_param #(.DATA_W(8), .ACC_W(32), .K_DEPTH(1)) u_c (
      .clk(clk), .reset(reset), .valid_in(valid_in), .signed_mode(signed_mode), .flush(flush),
      .a_in(a_in), .b_in(b_in), .a_out(ao[2]), .b_out(bo[2]), .valid_out(vo[2]),
      .y_out(y_c), .y_valid(yv[2]), .ovf_out(ov[2]));

   initial forever #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: running tile sum as a plain integer per instance.
   int     kd [3] = '{8, 8, 1};
   int     aw [3] = '{32, 16, 32};
   longint m_acc [3];
   longint m_y   [3];
   int     m_cnt [3];
   bit     m_yv  [3];
   bit     m_ovf [3];
   logic [7:0] e_a, e_b;
   bit     e_v;

   typedef struct {
      bit         v, sm, fl;
      logic [7:0] a, b;
      bit         eyv;
      longint     ey;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint mask(input int w);
      return (longint'(1) << w) - 1;
   endfunction

   function automatic longint norm(input longint x, input int w, output bit sat);
      longint hi, lo;
      hi  = (longint'(1) << (w - 1)) - 1;
      lo  = -(longint'(1) << (w - 1));
      sat = 1'b0;
`ifdef PE_SAT_EN
      if (x > hi) begin sat = 1'b1; return hi; end
      if (x < lo) begin sat = 1'b1; return lo; end
      return x;
`else
      x = x & mask(w);
      if (x > hi) x = x - (longint'(1) << w);
      return x;
`endif
   endfunction

   function automatic longint prod_of(input bit sm, input logic [7:0] a, input logic [7:0] b);
      if (sm) return longint'($signed(a)) * longint'($signed(b));
      return longint'(a) * longint'(b);
   endfunction

   function automatic longint get_y(input int i);
      case (i)
         0:       return longint'(y_a);
         1:       return longint'(y_b);
         default: return longint'(y_c);
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_acc[i] = 0; m_y[i] = 0; m_cnt[i] = 0; m_yv[i] = 1'b0; m_ovf[i] = 1'b0;
      end
      e_a = '0; e_b = '0; e_v = 1'b0;
   endtask

   task automatic model_update();
      longint s;
      bit     sat;
      for (int i = 0; i < 3; i++) begin
         m_yv[i] = 1'b0;
         if (valid_in) begin
            s = norm(m_acc[i] + prod_of(signed_mode, a_in, b_in), aw[i], sat);
            if (sat) m_ovf[i] = 1'b1;
            if (flush || m_cnt[i] == kd[i] - 1) begin
               m_y[i] = s; m_yv[i] = 1'b1; m_acc[i] = 0; m_cnt[i] = 0;
            end else begin
               m_acc[i] = s; m_cnt[i]++;
            end
         end else if (flush && m_cnt[i] > 0) begin
            m_y[i] = m_acc[i]; m_yv[i] = 1'b1; m_acc[i] = 0; m_cnt[i] = 0;
         end
      end
      e_v = valid_in;
      if (valid_in) begin e_a = a_in; e_b = b_in; end
   endtask

   task automatic compare_all(input string tag);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s y_valid[%0d]", tag, i), longint'(yv[i]), longint'(m_yv[i]));
         check($sformatf("%s y_out[%0d]", tag, i), get_y(i), m_y[i] & mask(aw[i]));
         check($sformatf("%s ovf_out[%0d]", tag, i), longint'(ov[i]), longint'(m_ovf[i]));
         check($sformatf("%s a_out[%0d]", tag, i), longint'(ao[i]), longint'(e_a));
         check($sformatf("%s b_out[%0d]", tag, i), longint'(bo[i]), longint'(e_b));
         check($sformatf("%s valid_out[%0d]", tag, i), longint'(vo[i]), longint'(e_v));
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      model_update();
      compare_all(tag);
   endtask

   task automatic drive(input bit v, input bit sm, input bit fl, input logic [7:0] a, input logic [7:0] b);
      valid_in = v; signed_mode = sm; flush = fl; a_in = a; b_in = b;
   endtask

   task automatic add(input bit v, input bit sm, input bit fl, input logic [7:0] a,
                      input logic [7:0] b, input bit eyv, input longint ey);
      vec_t t;
      t.v = v; t.sm = sm; t.fl = fl; t.a = a; t.b = b; t.eyv = eyv; t.ey = ey;
      vecs.push_back(t);
   endtask

   initial begin
      // Directed vectors; expectations are for the default-parameter instance.
      for (int k = 0; k < 8; k++) add(1, 1, 0, 8'd3, 8'hFE, k == 7, (k == 7) ? -48 : 0);
      add(0, 0, 0, 8'd0, 8'd0, 0, -48);
      for (int k = 0; k < 8; k++) add(1, 0, 0, 8'hFF, 8'hFF, k == 7, (k == 7) ? 520200 : -48);
      for (int k = 0; k < 8; k++) add(1, 1, 0, 8'hFF, 8'hFF, k == 7, (k == 7) ? 8 : 520200);
      for (int k = 1; k <= 16; k++)
         add(1, 0, 0, 8'd1, 8'(k), (k == 8) || (k == 16), (k < 8) ? 8 : (k < 16) ? 36 : 100);
      for (int k = 0; k < 3; k++) add(1, 1, 0, 8'd5, 8'd5, 0, 100);
      add(0, 0, 1, 8'd0, 8'd0, 1, 75);
      add(0, 0, 1, 8'd0, 8'd0, 0, 75);
      add(1, 1, 0, 8'd2, 8'd3, 0, 75);
      add(1, 1, 0, 8'd2, 8'd3, 0, 75);
      add(1, 1, 1, 8'd2, 8'd3, 1, 18);
      add(0, 0, 0, 8'd0, 8'd0, 0, 18);
      add(1, 1, 0, 8'hFF, 8'h02, 0, 18);
      add(1, 0, 0, 8'hFF, 8'h02, 0, 18);
      add(1, 1, 1, 8'hFF, 8'h02, 1, 506);

      reset = 1'b1;
      drive(0, 0, 0, 8'd0, 8'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].sm, vecs[i].fl, vecs[i].a, vecs[i].b);
         step($sformatf("vec%0d", i));
         check($sformatf("vec%0d y_valid", i), longint'(yv[0]), longint'(vecs[i].eyv));
         check($sformatf("vec%0d y_out", i), longint'($signed(y_a)), vecs[i].ey);
      end

      // Reset mid-tile: partial sum discarded, outputs cleared asynchronously.
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 0, 8'd7, 8'd7);
         step("pre_reset");
      end
      reset = 1'b1;
      #1;
      model_reset();
      compare_all("in_reset");
      drive(1, 1, 0, 8'd9, 8'd9);
      @(posedge clk);
      #1;
      compare_all("reset_hold");
      reset = 1'b0;
      drive(0, 0, 0, 8'd0, 8'd0);
      step("post_reset");
      for (int k = 0; k < 8; k++) begin
         drive(1, 1, 0, 8'd1, 8'd1);
         step("after_reset");
      end
      check("after_reset y_out", longint'(y_a), 64'd8);
      check("after_reset y_valid", longint'(yv[0]), 64'd1);

      // Random operands, modes and flushes.
      for (int n = 0; n < 300; n++) begin
         drive($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) == 0,
               8'($urandom), 8'($urandom));
         step($sformatf("rand%0d", n));
      end

      // 16-bit accumulator overflow corner.
      drive(0, 0, 1, 8'd0, 8'd0);
      step("drain");
      for (int k = 0; k < 8; k++) begin
         drive(1, 1, 0, 8'd127, 8'd127);
         step("ovf");
      end
`ifdef PE_SAT_EN
      check("ovf y_out16", longint'(y_b), 64'h7FFF);
      check("ovf ovf_out16", longint'(ov[1]), 64'd1);
`else
      check("ovf y_out16", longint'(y_b), 64'hF808);
      check("ovf ovf_out16", longint'(ov[1]), 64'd0);
`endif
      drive(0, 0, 0, 8'd0, 8'd0);
      step("ovf_hold");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
